// File: rtl/fft_serializer.sv
// Parallel-to-serial converter for FFT result frames.
// Captures N complex samples on load and streams one sample per accepted beat.
module fft_serializer #(
    parameter int N      = 16,
    parameter int WIDTH  = 16,
    parameter int BITREV = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [N*WIDTH-1:0]     datain_re,
    input  logic [N*WIDTH-1:0]     datain_im,
    input  logic                   dout_ready,
    output logic [WIDTH-1:0]       dataout_re,
    output logic [WIDTH-1:0]       dataout_im,
    output logic [$clog2(N)-1:0]   dout_index,
    output logic                   dout_valid,
    output logic                   dout_first,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   overrun
);
    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state, state_n;
    logic [N-1:0][WIDTH-1:0]    store_re, store_im;
    logic [LW-1:0]              cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0]           re_n, im_n;
    logic [LW-1:0]              idx_n;
    logic                       valid_n, first_n, last_n, overrun_n;
    logic                       xfer, at_last, acc;

    function automatic logic [LW-1:0] map_idx(input logic [LW-1:0] j);
        logic [LW-1:0] r;
        r = j;
        if (BITREV != 0) begin
            for (int i = 0; i < LW; i++) r[i] = j[LW-1-i];
        end
        return r;
    endfunction

    assign xfer    = dout_valid && dout_ready;
    assign at_last = (cnt == LAST);
    assign acc     = load && ((state == IDLE) || (xfer && at_last));
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        re_n      = dataout_re;
        im_n      = dataout_im;
        idx_n     = dout_index;
        valid_n   = dout_valid;
        first_n   = dout_first;
        last_n    = dout_last;
        overrun_n = 1'b0;
        if (acc) begin
            // map(0) is 0 in both orders, so beat 0 comes straight from the inputs
            state_n = SEND;
            cnt_n   = '0;
            re_n    = datain_re[0 +: WIDTH];
            im_n    = datain_im[0 +: WIDTH];
            idx_n   = '0;
            valid_n = 1'b1;
            first_n = 1'b1;
            last_n  = 1'b0;
        end else begin
            overrun_n = load;
            if (xfer) begin
                if (at_last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    re_n    = '0;
                    im_n    = '0;
                    idx_n   = '0;
                    valid_n = 1'b0;
                    first_n = 1'b0;
                    last_n  = 1'b0;
                end else begin
                    cnt_n   = cnt_inc;
                    idx_n   = map_idx(cnt_inc);
                    re_n    = store_re[map_idx(cnt_inc)];
                    im_n    = store_im[map_idx(cnt_inc)];
                    first_n = 1'b0;
                    last_n  = (cnt_inc == LAST);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            store_re   <= '0;
            store_im   <= '0;
            dataout_re <= '0;
            dataout_im <= '0;
            dout_index <= '0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            if (acc) begin
                store_re <= datain_re;
                store_im <= datain_im;
            end
            dataout_re <= re_n;
            dataout_im <= im_n;
            dout_index <= idx_n;
            dout_valid <= valid_n;
            dout_first <= first_n;
            dout_last  <= last_n;
            busy       <= (state_n == SEND);
            overrun    <= overrun_n;
        end
    end
endmodule
